// File: rtl/vmask_beat_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : vmask_beat_feeder
//  Purpose  : Upstream sequencer for the mask-population-count unit. It takes
//             one mask-reduction request, consumes byte-lane mask beats from
//             the VRF read path, applies vl tail masking and optional v0
//             masking, and emits registered beats to the popcount stage. A
//             drain gap after each request lets the popcount stage clear its
//             running count before the next request starts.
//  Ports    : clk, rst                      - clock, synchronous active-high reset
//             req_valid/req_ready           - request handshake
//             req_vl/req_sew/req_vm/req_addr - request operands
//             src_valid/src_ready           - mask beat handshake
//             src_m, src_v0                 - source mask and v0 mask (one bit per lane)
//             out_m0/out_valid/out_sew      - masked beat to popcount stage
//             out_start/out_end/out_addr    - beat framing and result address
//             busy                          - block is not idle
//  Revision : 1.0 - initial release
// ============================================================================
module vmask_beat_feeder #(
  parameter int REQ_DATA_WIDTH = 64,
  parameter int REQ_ADDR_WIDTH = 32,
  parameter int SEW_WIDTH      = 2,
  parameter int VL_WIDTH       = 16,
  parameter int DRAIN_CYCLES   = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [VL_WIDTH-1:0]         req_vl,
  input  logic [SEW_WIDTH-1:0]        req_sew,
  input  logic                        req_vm,
  input  logic [REQ_ADDR_WIDTH-1:0]   req_addr,
  input  logic                        src_valid,
  output logic                        src_ready,
  input  logic [REQ_DATA_WIDTH/8-1:0] src_m,
  input  logic [REQ_DATA_WIDTH/8-1:0] src_v0,
  output logic [REQ_DATA_WIDTH/8-1:0] out_m0,
  output logic                        out_valid,
  output logic [SEW_WIDTH-1:0]        out_sew,
  output logic                        out_start,
  output logic                        out_end,
  output logic [REQ_ADDR_WIDTH-1:0]   out_addr,
  output logic                        busy
);

  localparam int LANES  = REQ_DATA_WIDTH / 8;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  // One extra bit on the element counter so elem_base+epb never wraps.
  localparam int BASE_W = VL_WIDTH + 1;
  localparam int CNT_W  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ZERO  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t                      r_state;
  state_t                      w_state_next;

  logic [VL_WIDTH-1:0]         r_vl;
  logic [SEW_WIDTH-1:0]        r_sew;
  logic                        r_vm;
  logic [REQ_ADDR_WIDTH-1:0]   r_addr;
  logic [BASE_W-1:0]           r_elem_base;
  logic [CNT_W-1:0]            r_drain_cnt;

  logic                        w_accept;
  logic                        w_beat_fire;
  logic                        w_zero_fire;
  logic [BASE_W-1:0]           w_epb;
  logic [BASE_W-1:0]           w_next_base;
  logic                        w_beat_end;
  logic [LANE_W-1:0]           w_sub_mask;
  logic [LANES-1:0]            w_m0;

  assign w_epb       = BASE_W'(LANES) >> r_sew;
  assign w_next_base = r_elem_base + w_epb;
  assign w_beat_end  = (w_next_base >= {1'b0, r_vl});
  // Low lane-index bits that must be zero for a lane to hold an element.
  assign w_sub_mask  = ~({LANE_W{1'b1}} << r_sew);

  // Per-lane activity: element k sits at lane k<<sew; other lanes stay 0.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam logic [LANE_W-1:0] c_lane = LANE_W'(l);
    logic              w_aligned;
    logic [BASE_W-1:0] w_elem_idx;

    assign w_aligned  = ((c_lane & w_sub_mask) == '0);
    assign w_elem_idx = r_elem_base + BASE_W'(c_lane >> r_sew);
    assign w_m0[l]    = w_aligned && (w_elem_idx < {1'b0, r_vl}) &&
                        src_m[l] && (r_vm || src_v0[l]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    src_ready    = 1'b0;
    w_accept     = 1'b0;
    w_beat_fire  = 1'b0;
    w_zero_fire  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept     = 1'b1;
          w_state_next = (req_vl == '0) ? ST_ZERO : ST_RUN;
        end
      end
      ST_RUN: begin
        src_ready = 1'b1;
        if (src_valid) begin
          w_beat_fire = 1'b1;
          if (w_beat_end) begin
            w_state_next = ST_DRAIN;
          end
        end
      end
      ST_ZERO: begin
        w_zero_fire  = 1'b1;
        w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (int'(r_drain_cnt) >= DRAIN_CYCLES - 1) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Request context and element / drain counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vl        <= '0;
      r_sew       <= '0;
      r_vm        <= 1'b0;
      r_addr      <= '0;
      r_elem_base <= '0;
      r_drain_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_vl        <= req_vl;
        r_sew       <= req_sew;
        r_vm        <= req_vm;
        r_addr      <= req_addr;
        r_elem_base <= '0;
      end else if (w_beat_fire) begin
        r_elem_base <= w_next_base;
      end
      if (r_state == ST_DRAIN && w_state_next == ST_DRAIN) begin
        r_drain_cnt <= r_drain_cnt + 1'b1;
      end else begin
        r_drain_cnt <= '0;
      end
    end
  end

  // Registered beat outputs; every field returns to 0 when no beat fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_m0    <= '0;
      out_sew   <= '0;
      out_start <= 1'b0;
      out_end   <= 1'b0;
      out_addr  <= '0;
    end else begin
      out_valid <= 1'b0;
      out_m0    <= '0;
      out_sew   <= '0;
      out_start <= 1'b0;
      out_end   <= 1'b0;
      out_addr  <= '0;
      if (w_beat_fire) begin
        out_valid <= 1'b1;
        out_m0    <= w_m0;
        out_sew   <= r_sew;
        out_start <= (r_elem_base == '0);
        out_end   <= w_beat_end;
        out_addr  <= r_addr;
      end else if (w_zero_fire) begin
        out_valid <= 1'b1;
        out_sew   <= r_sew;
        out_start <= 1'b1;
        out_end   <= 1'b1;
        out_addr  <= r_addr;
      end
    end
  end

  assign busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_vmask_beat_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vmask_beat_feeder
//  Purpose  : Self-checking bench for vmask_beat_feeder. Table-driven requests
//             plus hand-written sequences for drain gap, source stalls and
//             mid-request reset. Expected beats are queued at request time and
//             popped by a monitor on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vmask_beat_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_vl;
  logic [1:0]  req_sew;
  logic        req_vm;
  logic [31:0] req_addr;
  logic        src_valid;
  logic        src_ready;
  logic [7:0]  src_m;
  logic [7:0]  src_v0;
  logic [7:0]  out_m0;
  logic        out_valid;
  logic [1:0]  out_sew;
  logic        out_start;
  logic        out_end;
  logic [31:0] out_addr;
  logic        busy;

  always #5 clk = ~clk;

  vmask_beat_feeder dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_vl    (req_vl),
    .req_sew   (req_sew),
    .req_vm    (req_vm),
    .req_addr  (req_addr),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_m     (src_m),
    .src_v0    (src_v0),
    .out_m0    (out_m0),
    .out_valid (out_valid),
    .out_sew   (out_sew),
    .out_start (out_start),
    .out_end   (out_end),
    .out_addr  (out_addr),
    .busy      (busy)
  );

  typedef struct packed {
    logic [7:0]  m0;
    logic        st;
    logic        en;
    logic [31:0] addr;
    logic [1:0]  sew;
  } beat_t;

  typedef struct {
    logic [15:0]     vl;
    logic [1:0]      sew;
    logic            vm;
    logic [7:0]      m;
    logic [7:0]      v0;
    int              nb;
    int              hs;
    logic [3:0][7:0] exp_m0;
  } vec_t;

  beat_t sb[$];
  vec_t  vecs[10];
  int    checks   = 0;
  int    failures = 0;
  int    hs_cnt   = 0;
  logic  mon_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: pops expected beats, checks quiet outputs, counts handshakes.
  always @(negedge clk) begin
    if (mon_en) begin
      if (src_valid && src_ready) hs_cnt++;
      if (out_valid) begin
        beat_t act_b;
        act_b = '{m0: out_m0, st: out_start, en: out_end, addr: out_addr, sew: out_sew};
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%h required=none", act_b);
        end else begin
          check("beat", act_b, sb.pop_front());
        end
      end else begin
        check("idle_outputs", {out_m0, out_start, out_end, out_addr, out_sew}, 64'd0);
      end
    end
  end

  task automatic push_beat(input logic [7:0] m0, input logic st, input logic en,
                           input logic [31:0] addr, input logic [1:0] sew);
    sb.push_back('{m0: m0, st: st, en: en, addr: addr, sew: sew});
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL req_ready_timeout actual=0 required=1");
    end
  endtask

  task automatic issue(input logic [15:0] vl, input logic [1:0] sew,
                       input logic vm, input logic [31:0] addr);
    wait_ready();
    req_valid = 1'b1;
    req_vl    = vl;
    req_sew   = sew;
    req_vm    = vm;
    req_addr  = addr;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  pat;
    logic [31:0] addr;
    int          n;

    vecs[0] = '{16'd8,  2'd0, 1'b1, 8'hFF, 8'h00, 1, 1, {8'h00, 8'h00, 8'h00, 8'hFF}};
    vecs[1] = '{16'd6,  2'd2, 1'b1, 8'hFF, 8'h00, 3, 3, {8'h00, 8'h11, 8'h11, 8'h11}};
    vecs[2] = '{16'd5,  2'd0, 1'b1, 8'hFF, 8'h00, 1, 1, {8'h00, 8'h00, 8'h00, 8'h1F}};
    vecs[3] = '{16'd8,  2'd0, 1'b0, 8'hFF, 8'h0F, 1, 1, {8'h00, 8'h00, 8'h00, 8'h0F}};
    vecs[4] = '{16'd0,  2'd0, 1'b1, 8'hFF, 8'hFF, 1, 0, {8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[5] = '{16'd3,  2'd1, 1'b1, 8'hFF, 8'h00, 1, 1, {8'h00, 8'h00, 8'h00, 8'h15}};
    vecs[6] = '{16'd12, 2'd0, 1'b1, 8'hA5, 8'h00, 2, 2, {8'h00, 8'h00, 8'h05, 8'hA5}};
    vecs[7] = '{16'd4,  2'd3, 1'b1, 8'hFE, 8'h00, 4, 4, {8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[8] = '{16'd4,  2'd2, 1'b0, 8'hFF, 8'h10, 2, 2, {8'h00, 8'h00, 8'h10, 8'h10}};
    vecs[9] = '{16'd16, 2'd0, 1'b1, 8'hFF, 8'h00, 2, 2, {8'h00, 8'h00, 8'hFF, 8'hFF}};

    rst = 1'b1; req_valid = 1'b0; req_vl = '0; req_sew = '0; req_vm = 1'b0;
    req_addr = '0; src_valid = 1'b0; src_m = '0; src_v0 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_src_ready", src_ready, 0);
    check("reset_outputs", {out_m0, out_start, out_end, out_addr, out_sew}, 0);
    @(posedge clk); #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Table-driven requests with a continuously valid source.
    for (int i = 0; i < 10; i++) begin
      addr      = 32'h1000 + 32'(i) * 32'h10;
      src_m     = vecs[i].m;
      src_v0    = vecs[i].v0;
      src_valid = 1'b1;
      hs_cnt    = 0;
      for (int b = 0; b < vecs[i].nb; b++)
        push_beat(vecs[i].exp_m0[b], b == 0, b == vecs[i].nb - 1, addr, vecs[i].sew);
      issue(vecs[i].vl, vecs[i].sew, vecs[i].vm, addr);
      wait_ready();
      check("handshakes", hs_cnt, vecs[i].hs);
      check("queue_empty", sb.size(), 0);
      src_valid = 1'b0;
    end

    // Drain gap: req_ready stays low for 6 cycles starting at the end beat.
    src_m = 8'hFF; src_v0 = 8'h00; src_valid = 1'b1;
    push_beat(8'hFF, 1'b1, 1'b1, 32'hD0D0_0001, 2'd0);
    issue(16'd8, 2'd0, 1'b1, 32'hD0D0_0001);
    n = 0;
    @(negedge clk);
    while (!out_end && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain_end_seen", out_end, 1);
    check("drain_ready_0", req_ready, 0);
    for (int k = 1; k < 6; k++) begin
      @(negedge clk);
      check("drain_ready_low", req_ready, 0);
    end
    @(negedge clk);
    check("drain_ready_back", req_ready, 1);
    @(posedge clk); #1;
    src_valid = 1'b0;

    // Source stalls with sew=3: each beat appears exactly one cycle after its handshake.
    pat = 6'b010101;
    hs_cnt = 0;
    push_beat(8'h01, 1'b1, 1'b0, 32'hCAFE_0003, 2'd3);
    push_beat(8'h01, 1'b0, 1'b0, 32'hCAFE_0003, 2'd3);
    push_beat(8'h01, 1'b0, 1'b1, 32'hCAFE_0003, 2'd3);
    issue(16'd3, 2'd3, 1'b1, 32'hCAFE_0003);
    for (int i = 0; i < 6; i++) begin
      src_valid = pat[i];
      @(negedge clk);
      check("toggle_valid", out_valid, (i > 0) ? pat[i-1] : 1'b0);
      if (i == 5) check("toggle_end", out_end, 1);
      @(posedge clk); #1;
    end
    src_valid = 1'b0;
    wait_ready();
    check("toggle_handshakes", hs_cnt, 3);
    check("toggle_queue_empty", sb.size(), 0);

    // Reset during the second beat of a four-beat request.
    src_m = 8'hFF; src_valid = 1'b1;
    push_beat(8'hFF, 1'b1, 1'b0, 32'hBEEF_0004, 2'd0);
    issue(16'd32, 2'd0, 1'b1, 32'hBEEF_0004);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_end", out_end, 0);
    check("rst_mid_queue", sb.size(), 0);
    @(posedge clk); #1;
    push_beat(8'hFF, 1'b1, 1'b1, 32'hBEEF_0005, 2'd0);
    issue(16'd8, 2'd0, 1'b1, 32'hBEEF_0005);
    wait_ready();
    check("post_rst_queue", sb.size(), 0);
    src_valid = 1'b0;

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vmask_beat_feeder.md
Name: vmask_beat_feeder

Overview:
- Upstream sequencer for the mask-population-count unit (vcpop.m path).
- Accepts one mask-reduction request (vl, sew, vm, result address), consumes byte-lane mask beats from the VRF read path, and applies vl tail masking and optional v0 masking.
- Emits per-beat in_m0/in_valid/in_sew/in_start/in_end/in_addr to the popcount stage.
- Enforces a drain gap so the popcount stage's running count resets before the next request starts.

Parameters:
- REQ_DATA_WIDTH, 64, VRF beat width in bits; mask lanes per beat = REQ_DATA_WIDTH/8.
- REQ_ADDR_WIDTH, 32, result address/tag width.
- SEW_WIDTH, 2, element-width encoding (0=8b, 1=16b, 2=32b, 3=64b).
- VL_WIDTH, 16, width of the vl operand and the element counter.
- DRAIN_CYCLES, 6, idle cycles after an end beat before the next request is accepted.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_vl  in  VL_WIDTH  number of active elements.
- req_sew  in  SEW_WIDTH  element width.
- req_vm  in  1  1 = unmasked; 0 = AND with v0.
- req_addr  in  REQ_ADDR_WIDTH  result destination address.
- src_valid  in  1  mask beat present.
- src_ready  out  1  beat consumed this cycle.
- src_m  in  REQ_DATA_WIDTH/8  source mask, one flag per byte lane.
- src_v0  in  REQ_DATA_WIDTH/8  v0 mask, byte-lane aligned like src_m.
- out_m0  out  REQ_DATA_WIDTH/8  masked beat to the popcount stage.
- out_valid  out  1  beat valid.
- out_sew  out  SEW_WIDTH  latched sew.
- out_start  out  1  first beat of the request.
- out_end  out  1  last beat of the request.
- out_addr  out  REQ_ADDR_WIDTH  latched req_addr; 0 when out_valid=0.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: single clock clk; synchronous active-high reset rst.
- Reset values: all outputs 0; state IDLE; counters 0.
- Derived terms:
  - epb (elements per beat) = (REQ_DATA_WIDTH/8) >> sew; for width 64 this is 8/4/2/1.
  - Element k of a beat lives at lane k<<sew.
  - Lanes that are not multiples of 2^sew are always driven 0.
- State IDLE:
  - req_ready=1; src_ready=0.
  - On req_valid: latch vl, sew, vm, addr; clear elem_base.
  - If vl==0 go to ZERO; otherwise go to RUN.
- State RUN:
  - src_ready=1.
  - On src_valid&src_ready (one beat):
    - element k is active iff elem_base+k < vl and src_m[lane] and (vm or src_v0[lane]).
    - out_m0[lane] = active.
    - Outputs are registered: out_valid=1 in the cycle after the handshake.
    - out_start=1 iff elem_base==0.
    - out_end=1 iff elem_base+epb >= vl.
    - elem_base += epb, computed at VL_WIDTH+1 bits so there is no wrap.
    - After the end beat, go to DRAIN.
  - No handshake: out_valid=0 the next cycle and all beat outputs are 0 (no duplication, no hold).
- State ZERO (vl==0):
  - Emit one beat with out_m0=0, out_start=out_end=1, latched addr.
  - Consume no source beat; src_ready stays 0.
  - Go to DRAIN.
- State DRAIN:
  - Count DRAIN_CYCLES cycles with req_ready=0 and src_ready=0, then return to IDLE.
  - Gap between an end beat and the next start beat is at least DRAIN_CYCLES+1 cycles.
- Beat count: beats per request = ceil(vl/epb). Tail beats zero lanes at or beyond vl.
- Excess source beats: src_ready=0 outside RUN, so beats beyond the end are never consumed.
- out_sew holds the latched sew while out_valid=1; it is 0 otherwise.
- No downstream backpressure: the popcount stage always accepts.
- Reset mid-operation:
  - Abandons the request with no end beat emitted.
  - Outputs are 0 the next cycle; state is IDLE.

Test Plan:
- vl=8, sew=0, vm=1, src_m=0xFF -> one beat, out_m0=0xFF, start=end=1, out_addr=req_addr.
- vl=6, sew=2, vm=1, three src beats of 0xFF -> beats 0x11, 0x11, 0x11; start on beat 0 only, end on beat 2 only.
- vl=5, sew=0 -> out_m0=0x1F. vl=8, sew=0, vm=0, src_m=0xFF, src_v0=0x0F -> out_m0=0x0F.
- vl=0 -> one beat, out_m0=0x00, start=end=1; src_ready never asserted.
- sew=3, vl=3, src_valid toggled 1,0,1,0,1 -> exactly three out_valid pulses 0x01, each one cycle after its handshake; end on the third.
- After an end beat, req_ready=0 for 6 cycles.
- rst asserted during beat 2 of 4 -> outputs 0 next cycle, busy=0, no out_end.
- New request after that reset -> starts with out_start=1.
